// File: rtl/lsu.sv
// Load/store stage: one aligned data access per instruction, load formatting, fault detection.
// Latency: non-memory op 1 cycle; memory op 2 cycles plus any request/response stall.
// Backpressure: LS_EX_ls_ready held low until write-back accepts; request held stable until req_ready.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_LS_reg_execute_valid,
    output logic        LS_EX_ls_ready,
    input  logic [63:0] EX_LS_reg_PC,
    input  logic [63:0] EX_LS_reg_next_PC,
    input  logic [31:0] EX_LS_reg_inst,
    input  logic        EX_LS_reg_trap_valid,
    input  logic        EX_LS_reg_mret_valid,
    input  logic        EX_LS_reg_sret_valid,
    input  logic        EX_LS_reg_dret_valid,
    input  logic [63:0] EX_LS_reg_trap_cause,
    input  logic [63:0] EX_LS_reg_trap_tval,
    input  logic        EX_LS_reg_csr_wen,
    input  logic        EX_LS_reg_csr_ren,
    input  logic [11:0] EX_LS_reg_csr_addr,
    input  logic [4:0]  EX_LS_reg_rd,
    input  logic        EX_LS_reg_dest_wen,
    input  logic [63:0] EX_LS_reg_data,
    input  logic [63:0] EX_LS_reg_store_data,
    input  logic        EX_LS_reg_load_valid,
    input  logic        EX_LS_reg_store_valid,
    input  logic [1:0]  EX_LS_reg_ls_size,
    input  logic        EX_LS_reg_load_signed,
    output logic        LS_MEM_req_valid,
    input  logic        MEM_LS_req_ready,
    output logic [63:0] LS_MEM_addr,
    output logic        LS_MEM_wen,
    output logic [63:0] LS_MEM_wdata,
    output logic [7:0]  LS_MEM_wstrb,
    input  logic        MEM_LS_rsp_valid,
    input  logic [63:0] MEM_LS_rdata,
    input  logic        MEM_LS_rsp_err,
    input  logic        WB_LS_ls_ready,
    input  logic        WB_LS_flush_flag,
    output logic        LS_WB_reg_ls_valid,
    output logic [63:0] LS_WB_reg_PC,
    output logic [63:0] LS_WB_reg_next_PC,
    output logic [31:0] LS_WB_reg_inst,
    output logic        LS_WB_reg_trap_valid,
    output logic        LS_WB_reg_mret_valid,
    output logic        LS_WB_reg_sret_valid,
    output logic        LS_WB_reg_dret_valid,
    output logic [63:0] LS_WB_reg_trap_cause,
    output logic [63:0] LS_WB_reg_trap_tval,
    output logic        LS_WB_reg_csr_wen,
    output logic        LS_WB_reg_csr_ren,
    output logic [11:0] LS_WB_reg_csr_addr,
    output logic [4:0]  LS_WB_reg_rd,
    output logic        LS_WB_reg_dest_wen,
    output logic [63:0] LS_WB_reg_data
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [63:0] addr;
    logic [2:0]  boff;
    logic        mem_op, misaligned, req, consume;
    logic [7:0]  strb_base;
    logic [63:0] shifted, load_data;
    logic        trap_nxt, dest_wen_nxt;
    logic [63:0] cause_nxt, tval_nxt, data_nxt;

    assign addr   = EX_LS_reg_data;
    assign boff   = addr[2:0];
    assign mem_op = EX_LS_reg_execute_valid & (EX_LS_reg_load_valid | EX_LS_reg_store_valid)
                  & ~EX_LS_reg_trap_valid;

    always_comb begin
        case (EX_LS_reg_ls_size)
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            2'd3:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // The execute register is held while we wait, so the address stays valid in WAIT.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (EX_LS_reg_execute_valid && !WB_LS_flush_flag) begin
                    if (mem_op && !misaligned) begin
                        req = 1'b1;
                        if (MEM_LS_req_ready) state_nxt = WAIT;
                    end else begin
                        consume = WB_LS_ls_ready;
                    end
                end
            end
            WAIT: begin
                if (WB_LS_flush_flag) begin
                    state_nxt = MEM_LS_rsp_valid ? IDLE : DRAIN;
                end else if (MEM_LS_rsp_valid && WB_LS_ls_ready) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (MEM_LS_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign LS_MEM_req_valid = req & rst_n;
    assign LS_EX_ls_ready   = consume & rst_n;

    always_comb begin
        case (EX_LS_reg_ls_size)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    assign LS_MEM_addr  = {addr[63:3], 3'b000};
    assign LS_MEM_wen   = EX_LS_reg_store_valid;
    assign LS_MEM_wstrb = EX_LS_reg_store_valid ? (strb_base << boff) : 8'h00;
    assign LS_MEM_wdata = EX_LS_reg_store_valid ? (EX_LS_reg_store_data << {boff, 3'b000}) : 64'd0;
    assign shifted      = MEM_LS_rdata >> {boff, 3'b000};

    always_comb begin
        case (EX_LS_reg_ls_size)
            2'd0:    load_data = {{56{EX_LS_reg_load_signed & shifted[7]}},  shifted[7:0]};
            2'd1:    load_data = {{48{EX_LS_reg_load_signed & shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = {{32{EX_LS_reg_load_signed & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        trap_nxt     = EX_LS_reg_trap_valid;
        cause_nxt    = EX_LS_reg_trap_cause;
        tval_nxt     = EX_LS_reg_trap_tval;
        dest_wen_nxt = EX_LS_reg_dest_wen;
        data_nxt     = EX_LS_reg_data;
        if (state == IDLE && mem_op && misaligned) begin
            trap_nxt     = 1'b1;
            cause_nxt    = EX_LS_reg_load_valid ? 64'd4 : 64'd6;
            tval_nxt     = addr;
            dest_wen_nxt = 1'b0;
        end else if (state == WAIT) begin
            if (MEM_LS_rsp_err) begin
                trap_nxt     = 1'b1;
                cause_nxt    = EX_LS_reg_load_valid ? 64'd5 : 64'd7;
                tval_nxt     = addr;
                dest_wen_nxt = 1'b0;
            end else if (EX_LS_reg_load_valid) begin
                data_nxt = load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            LS_WB_reg_ls_valid   <= 1'b0;
            LS_WB_reg_PC         <= 64'd0;
            LS_WB_reg_next_PC    <= 64'd0;
            LS_WB_reg_inst       <= 32'd0;
            LS_WB_reg_trap_valid <= 1'b0;
            LS_WB_reg_mret_valid <= 1'b0;
            LS_WB_reg_sret_valid <= 1'b0;
            LS_WB_reg_dret_valid <= 1'b0;
            LS_WB_reg_trap_cause <= 64'd0;
            LS_WB_reg_trap_tval  <= 64'd0;
            LS_WB_reg_csr_wen    <= 1'b0;
            LS_WB_reg_csr_ren    <= 1'b0;
            LS_WB_reg_csr_addr   <= 12'd0;
            LS_WB_reg_rd         <= 5'd0;
            LS_WB_reg_dest_wen   <= 1'b0;
            LS_WB_reg_data       <= 64'd0;
        end else begin
            state <= state_nxt;
            if (WB_LS_flush_flag)    LS_WB_reg_ls_valid <= 1'b0;
            else if (consume)        LS_WB_reg_ls_valid <= 1'b1;
            else if (WB_LS_ls_ready) LS_WB_reg_ls_valid <= 1'b0;
            if (consume) begin
                LS_WB_reg_PC         <= EX_LS_reg_PC;
                LS_WB_reg_next_PC    <= EX_LS_reg_next_PC;
                LS_WB_reg_inst       <= EX_LS_reg_inst;
                LS_WB_reg_trap_valid <= trap_nxt;
                LS_WB_reg_mret_valid <= EX_LS_reg_mret_valid;
                LS_WB_reg_sret_valid <= EX_LS_reg_sret_valid;
                LS_WB_reg_dret_valid <= EX_LS_reg_dret_valid;
                LS_WB_reg_trap_cause <= cause_nxt;
                LS_WB_reg_trap_tval  <= tval_nxt;
                LS_WB_reg_csr_wen    <= EX_LS_reg_csr_wen;
                LS_WB_reg_csr_ren    <= EX_LS_reg_csr_ren;
                LS_WB_reg_csr_addr   <= EX_LS_reg_csr_addr;
                LS_WB_reg_rd         <= EX_LS_reg_rd;
                LS_WB_reg_dest_wen   <= dest_wen_nxt;
                LS_WB_reg_data       <= data_nxt;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: an instruction-level model predicts each write-back bundle and request.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_LS_reg_execute_valid = 1'b0;
    logic        LS_EX_ls_ready;
    logic [63:0] EX_LS_reg_PC = '0, EX_LS_reg_next_PC = '0;
    logic [31:0] EX_LS_reg_inst = '0;
    logic        EX_LS_reg_trap_valid = 1'b0, EX_LS_reg_mret_valid = 1'b0;
    logic        EX_LS_reg_sret_valid = 1'b0, EX_LS_reg_dret_valid = 1'b0;
    logic [63:0] EX_LS_reg_trap_cause = '0, EX_LS_reg_trap_tval = '0;
    logic        EX_LS_reg_csr_wen = 1'b0, EX_LS_reg_csr_ren = 1'b0;
    logic [11:0] EX_LS_reg_csr_addr = '0;
    logic [4:0]  EX_LS_reg_rd = '0;
    logic        EX_LS_reg_dest_wen = 1'b0;
    logic [63:0] EX_LS_reg_data = '0, EX_LS_reg_store_data = '0;
    logic        EX_LS_reg_load_valid = 1'b0, EX_LS_reg_store_valid = 1'b0;
    logic [1:0]  EX_LS_reg_ls_size = '0;
    logic        EX_LS_reg_load_signed = 1'b0;
    logic        LS_MEM_req_valid, MEM_LS_req_ready = 1'b0;
    logic [63:0] LS_MEM_addr, LS_MEM_wdata;
    logic        LS_MEM_wen;
    logic [7:0]  LS_MEM_wstrb;
    logic        MEM_LS_rsp_valid = 1'b0, MEM_LS_rsp_err = 1'b0;
    logic [63:0] MEM_LS_rdata = '0;
    logic        WB_LS_ls_ready = 1'b1, WB_LS_flush_flag = 1'b0;
    logic        LS_WB_reg_ls_valid, LS_WB_reg_trap_valid, LS_WB_reg_mret_valid;
    logic        LS_WB_reg_sret_valid, LS_WB_reg_dret_valid, LS_WB_reg_csr_wen, LS_WB_reg_csr_ren;
    logic        LS_WB_reg_dest_wen;
    logic [63:0] LS_WB_reg_PC, LS_WB_reg_next_PC, LS_WB_reg_trap_cause, LS_WB_reg_trap_tval;
    logic [63:0] LS_WB_reg_data;
    logic [31:0] LS_WB_reg_inst;
    logic [11:0] LS_WB_reg_csr_addr;
    logic [4:0]  LS_WB_reg_rd;

    lsu dut (.*);

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc, data, store_data, up_cause, up_tval;
        logic [4:0]  rd;
        logic        dest_wen, ld, st, sgn, up_trap;
        logic [1:0]  size;
    } ins_t;
    typedef struct {
        logic [63:0] pc, data, cause, tval;
        logic [4:0]  rd;
        logic        trap, dest_wen, chk_data;
    } wb_t;

    wb_t         expq[$];
    int          errors = 0, checks = 0, cyc = 0;
    logic        req_allowed = 1'b0;
    ins_t        cur;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_wen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [63:0] pc, input logic [63:0] data, input logic [4:0] rd,
                                input logic ld, input logic st, input logic [1:0] size,
                                input logic sgn, input logic [63:0] sdata);
        ins_t i;
        i.pc = pc; i.data = data; i.rd = rd; i.ld = ld; i.st = st; i.size = size; i.sgn = sgn;
        i.store_data = sdata; i.dest_wen = !st; i.up_trap = 1'b0; i.up_cause = '0; i.up_tval = '0;
        return i;
    endfunction

    function automatic logic is_mem(input ins_t i);
        return (i.ld || i.st) && !i.up_trap;
    endfunction

    function automatic logic is_mis(input ins_t i);
        return (i.data % (64'd1 << i.size)) != 64'd0;
    endfunction

    function automatic logic [63:0] m_wdata(input ins_t i);
        return i.st ? (i.store_data << (8 * (i.data % 8))) : 64'd0;
    endfunction

    function automatic logic [7:0] m_wstrb(input ins_t i);
        logic [15:0] s;
        s = ((16'd1 << (1 << i.size)) - 16'd1) << (i.data % 8);
        return i.st ? s[7:0] : 8'h00;
    endfunction

    function automatic wb_t model_wb(input ins_t i, input logic [63:0] rdata, input logic err);
        wb_t w;
        int nb;
        logic [63:0] v, mask;
        w.pc = i.pc; w.rd = i.rd; w.dest_wen = i.dest_wen; w.trap = i.up_trap;
        w.cause = i.up_cause; w.tval = i.up_tval; w.data = i.data; w.chk_data = 1'b1;
        if (is_mem(i)) begin
            if (is_mis(i) || err) begin
                w.trap = 1'b1; w.tval = i.data; w.dest_wen = 1'b0; w.chk_data = 1'b0;
                w.cause = is_mis(i) ? (i.ld ? 64'd4 : 64'd6) : (i.ld ? 64'd5 : 64'd7);
            end else if (i.ld) begin
                nb   = 1 << i.size;
                v    = rdata >> (8 * (i.data % 8));
                mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
                v    = v & mask;
                if (i.sgn && v[8 * nb - 1]) v = v | ~mask;
                w.data = v;
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin : compare
        wb_t e;
        if (rst_n) begin
            if (LS_MEM_req_valid) begin
                if (!req_allowed) chk("unexpected_req", LS_MEM_req_valid, 1'b0);
                else begin
                    chk("req_addr", LS_MEM_addr, cur.data - (cur.data % 8));
                    chk("req_wen", LS_MEM_wen, cur.st);
                    chk("req_wstrb", LS_MEM_wstrb, m_wstrb(cur));
                    if (cur.st) chk("req_wdata", LS_MEM_wdata, m_wdata(cur));
                end
            end
            if (LS_WB_reg_ls_valid && WB_LS_ls_ready) begin
                if (expq.size() == 0) chk("spurious_wb", LS_WB_reg_ls_valid, 1'b0);
                else begin
                    e = expq.pop_front();
                    chk("wb_pc", LS_WB_reg_PC, e.pc);
                    chk("wb_next_pc", LS_WB_reg_next_PC, e.pc + 64'd4);
                    chk("wb_inst", LS_WB_reg_inst, {32'd0, e.pc[31:0] ^ 32'h13});
                    chk("wb_rd", LS_WB_reg_rd, e.rd);
                    chk("wb_dest_wen", LS_WB_reg_dest_wen, e.dest_wen);
                    chk("wb_trap", LS_WB_reg_trap_valid, e.trap);
                    chk("wb_cause", LS_WB_reg_trap_cause, e.cause);
                    chk("wb_tval", LS_WB_reg_trap_tval, e.tval);
                    chk("wb_csr_addr", LS_WB_reg_csr_addr, e.pc[11:0]);
                    chk("wb_flags", {LS_WB_reg_mret_valid, LS_WB_reg_sret_valid, LS_WB_reg_dret_valid,
                                     LS_WB_reg_csr_wen, LS_WB_reg_csr_ren}, 5'd0);
                    if (e.chk_data) chk("wb_data", LS_WB_reg_data, e.data);
                end
            end
        end
    end

    task automatic set_ins(input ins_t i);
        cur = i;
        EX_LS_reg_PC = i.pc; EX_LS_reg_next_PC = i.pc + 64'd4; EX_LS_reg_inst = i.pc[31:0] ^ 32'h13;
        EX_LS_reg_trap_valid = i.up_trap; EX_LS_reg_trap_cause = i.up_cause; EX_LS_reg_trap_tval = i.up_tval;
        EX_LS_reg_csr_addr = i.pc[11:0]; EX_LS_reg_rd = i.rd; EX_LS_reg_dest_wen = i.dest_wen;
        EX_LS_reg_data = i.data; EX_LS_reg_store_data = i.store_data;
        EX_LS_reg_load_valid = i.ld; EX_LS_reg_store_valid = i.st;
        EX_LS_reg_ls_size = i.size; EX_LS_reg_load_signed = i.sgn;
        EX_LS_reg_execute_valid = 1'b1;
    endtask

    // Entered just after a rising edge; returns just after the edge that consumed the instruction.
    task automatic run(input ins_t i, input int req_stall, input int rsp_delay,
                       input logic [63:0] rdata, input logic err);
        logic hit;
        set_ins(i);
        hit = 1'b0;
        if (!is_mem(i) || is_mis(i)) begin
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clk);
                hit = LS_EX_ls_ready;
                if (!hit) begin @(posedge clk); #1; end
            end
            chk("consume", hit, 1'b1);
        end else begin
            req_allowed = 1'b1;
            for (int c = 0; c < 20 && !hit; c++) begin
                MEM_LS_req_ready = (c >= req_stall);
                @(negedge clk);
                chk("req_valid", LS_MEM_req_valid, 1'b1);
                chk("ex_ready_held", LS_EX_ls_ready, 1'b0);
                hit = MEM_LS_req_ready;
                cap_addr = LS_MEM_addr; cap_wdata = LS_MEM_wdata; cap_wstrb = LS_MEM_wstrb; cap_wen = LS_MEM_wen;
                if (!hit) begin @(posedge clk); #1; end
            end
            @(posedge clk); #1;
            MEM_LS_req_ready = 1'b0; req_allowed = 1'b0;
            for (int c = 0; c <= rsp_delay; c++) begin
                MEM_LS_rsp_valid = (c == rsp_delay); MEM_LS_rdata = rdata; MEM_LS_rsp_err = err;
                @(negedge clk);
                chk("rsp_consume", LS_EX_ls_ready, c == rsp_delay);
                if (c < rsp_delay) begin @(posedge clk); #1; end
            end
        end
        expq.push_back(model_wb(i, rdata, err));
        @(posedge clk); #1;
        MEM_LS_rsp_valid = 1'b0; MEM_LS_rsp_err = 1'b0; EX_LS_reg_execute_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        ins_t a, b;
        int t0;
        rst_n = 1'b0;
        set_ins(mk(64'h80, 64'h55, 5'd1, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0));
        MEM_LS_req_ready = 1'b1;
        #12;
        chk("rst_ex_ready", LS_EX_ls_ready, 1'b0);
        chk("rst_ls_valid", LS_WB_reg_ls_valid, 1'b0);
        chk("rst_data", LS_WB_reg_data, 64'd0);
        set_ins(mk(64'h84, 64'h1000, 5'd1, 1'b1, 1'b0, 2'd0, 1'b0, 64'd0));
        #6;
        chk("rst_req_valid", LS_MEM_req_valid, 1'b0);
        EX_LS_reg_execute_valid = 1'b0; MEM_LS_req_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        t0 = cyc; run(mk(64'h100, 64'h1234, 5'd5, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0), 0, 0, 64'd0, 1'b0);
        chk("add_lat", 64'(cyc - t0), 64'd1);
        chk("add_valid", LS_WB_reg_ls_valid, 1'b1);
        chk("add_data", LS_WB_reg_data, 64'h1234);
        chk("add_rd", LS_WB_reg_rd, 64'd5);

        t0 = cyc; run(mk(64'h104, 64'h1003, 5'd6, 1'b1, 1'b0, 2'd0, 1'b1, 64'd0), 0, 0, 64'h8000_0000_0000_0000, 1'b0);
        chk("lb_lat", 64'(cyc - t0), 64'd2);
        chk("lb_addr", cap_addr, 64'h1000);
        chk("lb_data0", LS_WB_reg_data, 64'h0);
        run(mk(64'h108, 64'h1003, 5'd6, 1'b1, 1'b0, 2'd0, 1'b1, 64'd0), 0, 0, 64'h0000_0000_8000_0000, 1'b0);
        chk("lb_sext", LS_WB_reg_data, 64'hFFFF_FFFF_FFFF_FF80);
        run(mk(64'h10C, 64'h1003, 5'd6, 1'b1, 1'b0, 2'd0, 1'b0, 64'd0), 0, 0, 64'h0000_0000_8000_0000, 1'b0);
        chk("lbu_zext", LS_WB_reg_data, 64'h80);

        run(mk(64'h110, 64'h2006, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 64'hABCD), 0, 0, 64'd0, 1'b0);
        chk("sh_wstrb", cap_wstrb, 64'hC0);
        chk("sh_wdata", cap_wdata, 64'hABCD_0000_0000_0000);
        chk("sh_wen", cap_wen, 1'b1);
        chk("sh_wb_data", LS_WB_reg_data, 64'h2006);
        chk("model_sh_wstrb", m_wstrb(cur), 64'hC0);

        run(mk(64'h114, 64'h1002, 5'd7, 1'b1, 1'b0, 2'd2, 1'b1, 64'd0), 0, 0, 64'd0, 1'b0);
        chk("lw_mis_trap", LS_WB_reg_trap_valid, 1'b1);
        chk("lw_mis_cause", LS_WB_reg_trap_cause, 64'd4);
        chk("lw_mis_tval", LS_WB_reg_trap_tval, 64'h1002);
        chk("lw_mis_dwen", LS_WB_reg_dest_wen, 1'b0);
        run(mk(64'h118, 64'h2001, 5'd0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h77), 0, 0, 64'd0, 1'b0);
        chk("sd_mis_cause", LS_WB_reg_trap_cause, 64'd6);
        chk("sd_mis_tval", LS_WB_reg_trap_tval, 64'h2001);

        t0 = cyc; run(mk(64'h11C, 64'h1008, 5'd8, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0), 3, 0, 64'h1, 1'b1);
        chk("ld_err_lat", 64'(cyc - t0), 64'd5);
        chk("ld_err_cause", LS_WB_reg_trap_cause, 64'd5);
        chk("ld_err_tval", LS_WB_reg_trap_tval, 64'h1008);
        run(mk(64'h120, 64'h2010, 5'd0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h5), 0, 1, 64'd0, 1'b1);
        chk("sd_err_cause", LS_WB_reg_trap_cause, 64'd7);

        t0 = cyc; run(mk(64'h124, 64'h100C, 5'd9, 1'b1, 1'b0, 2'd1, 1'b1, 64'd0), 0, 2, 64'h0000_8001_0000_0000, 1'b0);
        chk("lh_lat", 64'(cyc - t0), 64'd4);
        chk("lh_sext", LS_WB_reg_data, 64'hFFFF_FFFF_FFFF_8001);
        run(mk(64'h128, 64'h2004, 5'd0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h1122_3344), 1, 0, 64'd0, 1'b0);
        chk("sw_wstrb", cap_wstrb, 64'hF0);
        chk("sw_wdata", cap_wdata, 64'h1122_3344_0000_0000);
        run(mk(64'h12C, 64'h3004, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0), 0, 0, 64'hFEDC_BA98_0000_0000, 1'b0);
        chk("lwu_data", LS_WB_reg_data, 64'hFEDC_BA98);
        run(mk(64'h130, 64'h3000, 5'd11, 1'b1, 1'b0, 2'd3, 1'b1, 64'd0), 0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);
        chk("ld_data", LS_WB_reg_data, 64'hFEDC_BA98_7654_3210);

        a = mk(64'h134, 64'h1001, 5'd12, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0);
        a.up_trap = 1'b1; a.up_cause = 64'd2; a.up_tval = 64'hDEAD;
        run(a, 0, 0, 64'd0, 1'b0);
        chk("uptrap_cause", LS_WB_reg_trap_cause, 64'd2);

        set_ins(mk(64'h138, 64'h77, 5'd3, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0));
        WB_LS_ls_ready = 1'b0;
        @(negedge clk); chk("wb_stall_ready", LS_EX_ls_ready, 1'b0);
        @(posedge clk); #1; WB_LS_ls_ready = 1'b1;
        run(cur, 0, 0, 64'd0, 1'b0);
        idle(1);
        MEM_LS_rsp_valid = 1'b1; idle(1); MEM_LS_rsp_valid = 1'b0;

        // Flush while waiting: the late response is drained and a new load stays parked.
        a = mk(64'h200, 64'h4000, 5'd13, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
        b = mk(64'h204, 64'h1004, 5'd14, 1'b1, 1'b0, 2'd2, 1'b1, 64'd0);
        set_ins(a); req_allowed = 1'b1; MEM_LS_req_ready = 1'b1;
        @(negedge clk); chk("fl_req", LS_MEM_req_valid, 1'b1);
        @(posedge clk); #1; MEM_LS_req_ready = 1'b0; req_allowed = 1'b0;
        WB_LS_flush_flag = 1'b1; EX_LS_reg_execute_valid = 1'b0;
        @(negedge clk); chk("fl_ready", LS_EX_ls_ready, 1'b0);
        @(posedge clk); #1; WB_LS_flush_flag = 1'b0; set_ins(b);
        @(negedge clk); chk("drain_no_req", LS_MEM_req_valid, 1'b0);
        @(posedge clk); #1; MEM_LS_rsp_valid = 1'b1; MEM_LS_rdata = 64'hBAD;
        @(negedge clk); chk("drain_rsp_req", LS_MEM_req_valid, 1'b0);
        chk("drain_rsp_ready", LS_EX_ls_ready, 1'b0);
        @(posedge clk); #1; MEM_LS_rsp_valid = 1'b0;
        chk("fl_ls_valid", LS_WB_reg_ls_valid, 1'b0);
        run(b, 0, 0, 64'h8765_4321_0000_0000, 1'b0);
        chk("post_drain_data", LS_WB_reg_data, 64'hFFFF_FFFF_8765_4321);

        // Flush coinciding with the response goes straight back to IDLE.
        idle(1);
        set_ins(a); req_allowed = 1'b1; MEM_LS_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; MEM_LS_req_ready = 1'b0; req_allowed = 1'b0;
        WB_LS_flush_flag = 1'b1; MEM_LS_rsp_valid = 1'b1; EX_LS_reg_execute_valid = 1'b0;
        @(posedge clk); #1; WB_LS_flush_flag = 1'b0; MEM_LS_rsp_valid = 1'b0;
        run(mk(64'h208, 64'h3000, 5'd15, 1'b1, 1'b0, 2'd0, 1'b0, 64'd0), 0, 0, 64'hF1, 1'b0);
        chk("skip_drain_data", LS_WB_reg_data, 64'hF1);

        idle(3);
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
